// File: rtl/cart_mem_arb_if.sv
// Bus bundle for cart_mem_arb: download stream, core read handshake and the
// single cartridge memory port. The arbiter uses the slave view.
interface cart_mem_arb_if #(
  parameter int ADDR_W = 15
);
  logic              dl_active;
  logic              dl_wr;
  logic [7:0]        dl_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [7:0]        mem_rdata;

  modport slave (
    input  dl_active, dl_wr, dl_data, cpu_req, cpu_addr, mem_rdata,
    output cpu_ack, cpu_data, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output dl_active, dl_wr, dl_data, cpu_req, cpu_addr, mem_rdata,
    input  cpu_ack, cpu_data, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/cart_mem_arb.sv
// Shares one cartridge memory port between ROM download writes and core reads,
// holds the emulated core in reset around downloads and mirrors reads to ROM size.
module cart_mem_arb #(
  parameter int HOLD_CYC = 16,
  parameter int ADDR_W   = 15
) (
  input  logic            clk_i,
  input  logic            reset_i,
  cart_mem_arb_if.slave   bus,
  output logic            core_reset_o,
  output logic [ADDR_W:0] rom_size_o,
  output logic            dl_overflow_o
);

  localparam int HCW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYC - 1);
  localparam logic [ADDR_W:0] ROM_MAX   = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              rd_pend_q, rd_pend_d;
  logic              ack_q, ack_d;
  logic              core_reset_q, core_reset_d;

  // Smallest mirror window covering the loaded image; an empty image maps as 4 KiB.
  function automatic logic [ADDR_W-1:0] mirror_mask(input logic [ADDR_W:0] size);
    logic [ADDR_W-1:0] m;
    if (size == '0) begin
      m = ADDR_W'(16'h0FFF);
    end else if (size <= (ADDR_W+1)'(32'd2048)) begin
      m = ADDR_W'(16'h07FF);
    end else if (size <= (ADDR_W+1)'(32'd4096)) begin
      m = ADDR_W'(16'h0FFF);
    end else if (size <= (ADDR_W+1)'(32'd8192)) begin
      m = ADDR_W'(16'h1FFF);
    end else if (size <= (ADDR_W+1)'(32'd16384)) begin
      m = ADDR_W'(16'h3FFF);
    end else begin
      m = ADDR_W'(16'h7FFF);
    end
    return m;
  endfunction

  // Next-state and datapath decisions for the HOLD/RUN/LOAD controller.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    ovf_d       = ovf_q;
    mask_d      = mask_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_pend_d   = 1'b0;
    ack_d       = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (bus.dl_active) begin
          state_d    = ST_LOAD;
          hold_cnt_d = '0;
          wr_cnt_d   = '0;
          ovf_d      = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end

      ST_RUN: begin
        // A read accepted last cycle completes even if a download is starting.
        ack_d = rd_pend_q;
        if (bus.dl_active && !rd_pend_q) begin
          state_d  = ST_LOAD;
          wr_cnt_d = '0;
          ovf_d    = 1'b0;
        end else if (bus.cpu_req && !rd_pend_q && !ack_q && !bus.dl_active) begin
          rd_pend_d  = 1'b1;
          mem_addr_d = bus.cpu_addr & mask_q;
        end else begin
          rd_pend_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (bus.dl_wr) begin
          if (wr_cnt_q != ROM_MAX) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_cnt_q[ADDR_W-1:0];
            mem_wdata_d = bus.dl_data;
            wr_cnt_d    = wr_cnt_q + (ADDR_W+1)'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          mem_we_d = 1'b0;
        end
        if (!bus.dl_active) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          mask_d     = mirror_mask(wr_cnt_d);
        end else begin
          state_d = ST_LOAD;
        end
      end

      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
    endcase

    core_reset_d = (state_d != ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      wr_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      mask_q       <= ADDR_W'(16'h0FFF);
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h00;
      mem_we_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      ack_q        <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      ovf_q        <= ovf_d;
      mask_q       <= mask_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rd_pend_q    <= rd_pend_d;
      ack_q        <= ack_d;
      core_reset_q <= core_reset_d;
    end
  end

  // Memory read data arrives in the ack cycle, so it is steered straight through.
  assign bus.cpu_ack    = ack_q;
  assign bus.cpu_data   = ack_q ? bus.mem_rdata : 8'h00;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign core_reset_o   = core_reset_q;
  assign rom_size_o     = wr_cnt_q;
  assign dl_overflow_o  = ovf_q;

endmodule

// File: tb/tb_cart_mem_arb.sv
// Randomised self-checking bench for cart_mem_arb with a synchronous-read memory
// and a reference ROM image / mirror-window model.
module tb_cart_mem_arb;
  localparam int AW   = 15;
  localparam int HOLD = 16;
  localparam int MSZ  = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  logic core_reset;
  logic [AW:0] rom_size;
  logic dl_overflow;
  logic init_req;

  always #5 clk = ~clk;

  cart_mem_arb_if #(.ADDR_W(AW)) bus();

  cart_mem_arb #(.HOLD_CYC(HOLD), .ADDR_W(AW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .bus          (bus),
    .core_reset_o (core_reset),
    .rom_size_o   (rom_size),
    .dl_overflow_o(dl_overflow)
  );

  logic [7:0] mem     [MSZ];
  logic [7:0] ref_img [MSZ];
  logic [7:0] dl_bytes[$];
  int  wr_seen;
  int  exp_mask;
  bit  allow_we;
  bit  ack_allowed;
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic logic [7:0] init_byte(int i);
    return 8'((i * 37) + 11);
  endfunction

  // Cartridge memory: one write port, registered read.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < MSZ; i++) mem[i] <= init_byte(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mirror window: next power of two at or above the size, from 2 KiB up to the full space.
  function automatic int model_mask(int size);
    int p;
    if (size == 0) return 4095;
    p = 2048;
    while (p < size && p < MSZ) p = p * 2;
    return p - 1;
  endfunction

  // Every memory write must be the next byte of the current download.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      chk("we_allowed", 32'(allow_we), 32'd1);
      chk("wr_addr", 32'(bus.mem_addr), 32'(wr_seen));
      chk("wr_data", 32'(bus.mem_wdata),
          (wr_seen < dl_bytes.size()) ? 32'(dl_bytes[wr_seen]) : 32'hFFFF_FFFF);
      wr_seen++;
    end
    if (bus.cpu_ack) chk("ack_allowed", 32'(ack_allowed), 32'd1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic count_hold(string tag);
    int n = 0;
    while (core_reset && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(HOLD));
  endtask

  task automatic do_read(string tag, logic [AW-1:0] a);
    int n = 0;
    logic [AW-1:0] ea;
    ea = a & AW'(exp_mask);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    ack_allowed  = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(ea));
    end while (!bus.cpu_ack && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_data"}, 32'(bus.cpu_data), 32'(ref_img[ea]));
    #1 ack_allowed = 1'b0;
    tick();
    chk({tag, "_pulse"}, 32'(bus.cpu_ack), 32'd0);
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic dl_start();
    dl_bytes.delete();
    wr_seen        = 0;
    allow_we       = 1'b1;
    bus.dl_active  = 1'b1;
    tick();
    tick();
  endtask

  task automatic dl_bytes_send(int n, bit rnd, bit gaps);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(i);
      dl_bytes.push_back(b);
      if (i < MSZ) ref_img[i] = b;
      bus.dl_wr   = 1'b1;
      bus.dl_data = b;
      tick();
      bus.dl_wr = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    bus.dl_wr = 1'b0;
  endtask

  task automatic dl_finish(string tag, int n);
    int kept;
    kept = (n > MSZ) ? MSZ : n;
    tick();
    tick();
    chk({tag, "_wrcnt"}, 32'(wr_seen), 32'(kept));
    chk({tag, "_size"}, 32'(rom_size), 32'(kept));
    chk({tag, "_ovf"}, 32'(dl_overflow), (n > MSZ) ? 32'd1 : 32'd0);
    chk({tag, "_cr_load"}, 32'(core_reset), 32'd1);
    bus.dl_active = 1'b0;
    exp_mask      = model_mask(kept);
    tick();
    allow_we = 1'b0;
    count_hold({tag, "_hold"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset         = 1'b1;
    init_req      = 1'b1;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_data   = 8'h00;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    allow_we      = 1'b0;
    ack_allowed   = 1'b0;
    wr_seen       = 0;
    exp_mask      = 4095;
    for (int i = 0; i < MSZ; i++) ref_img[i] = init_byte(i);
    repeat (3) tick();
    init_req = 1'b0;
    tick();

    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_cpu_data", 32'(bus.cpu_data), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_size", 32'(rom_size), 32'd0);
    chk("rst_ovf", 32'(dl_overflow), 32'd0);

    reset = 1'b0;
    count_hold("hold_after_reset");
    do_read("rd1234", 15'h1234);
    chk("rd1234_mirror", 32'(bus.mem_addr), 32'h0234);

    dl_start();
    dl_bytes_send(2048, 1'b0, 1'b0);
    dl_finish("dl2k", 2048);
    do_read("rd0fff", 15'h0FFF);
    chk("rd0fff_mirror", 32'(bus.mem_addr), 32'h07FF);
    chk("rd0fff_img", 32'(ref_img[15'h07FF]), 32'hFF);

    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 4000);
      dl_start();
      dl_bytes_send(n, 1'b1, 1'b1);
      dl_finish("dlrnd", n);
      repeat (4) do_read("rdrnd", AW'($urandom));
    end

    // Read accepted, download request one cycle later: read drains, then LOAD.
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = AW'($urandom);
    ack_allowed  = 1'b1;
    tick();
    chk("drain_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr & AW'(exp_mask)));
    bus.dl_active = 1'b1;
    tick();
    chk("drain_ack", 32'(bus.cpu_ack), 32'd1);
    chk("drain_data", 32'(bus.cpu_data), 32'(ref_img[bus.cpu_addr & AW'(exp_mask)]));
    #1 ack_allowed = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    chk("drain_core_reset", 32'(core_reset), 32'd1);
    dl_bytes.delete();
    wr_seen  = 0;
    allow_we = 1'b1;
    dl_finish("dl_empty", 0);
    do_read("rd_empty", AW'($urandom));

    // Download and read start together: download wins, read waits for RUN.
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = AW'($urandom);
    bus.dl_active = 1'b1;
    repeat (5) tick();
    chk("collide_core_reset", 32'(core_reset), 32'd1);
    bus.dl_active = 1'b0;
    exp_mask      = model_mask(0);
    tick();
    count_hold("collide_hold");
    ack_allowed = 1'b1;
    n = 0;
    while (!bus.cpu_ack && n < 20) begin
      tick();
      n++;
    end
    chk("collide_lat", 32'(n), 32'd2);
    chk("collide_data", 32'(bus.cpu_data), 32'(ref_img[bus.cpu_addr & AW'(exp_mask)]));
    #1 ack_allowed = 1'b0;
    bus.cpu_req = 1'b0;
    tick();

    // Reset in the middle of a download.
    dl_start();
    dl_bytes_send(100, 1'b1, 1'b0);
    tick();
    reset         = 1'b1;
    bus.dl_active = 1'b0;
    tick();
    allow_we = 1'b0;
    chk("midrst_size", 32'(rom_size), 32'd0);
    chk("midrst_ovf", 32'(dl_overflow), 32'd0);
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_we", 32'(bus.mem_we), 32'd0);
    reset    = 1'b0;
    exp_mask = 4095;
    count_hold("midrst_hold");
    repeat (5) begin
      bus.dl_wr   = 1'b1;
      bus.dl_data = 8'($urandom);
      tick();
      bus.dl_wr = 1'b0;
      tick();
    end
    chk("midrst_size_after", 32'(rom_size), 32'd0);
    do_read("rd_midrst", AW'($urandom_range(0, 99)));

    // Overflowing download.
    dl_start();
    dl_bytes_send(MSZ + 1, 1'b1, 1'b0);
    dl_finish("dl_ovf", MSZ + 1);
    chk("dl_ovf_mask", 32'(exp_mask), 32'h7FFF);
    repeat (4) do_read("rd_full", AW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
